arith_sequencer: RTL and testbench
==================================

ARITH_SEQUENCER -- requirements
Module: arith_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32: max WAIT-state cycles before abort; legal range 2..255.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1; cmd_ready  out  1: command handshake, transfer when both high on a rising edge.
REQ-005 cmd_op  in  2  00=LDR, 01=ADD, 10=SUB, 11=MUL; cmd_signed  in  1  two's-complement mode.
REQ-006 cmd_a  in  8; cmd_b  in  8: operands, captured at handshake.
REQ-007 dp_data  out  8; dp_reg  out  2 (0=A_lo,1=A_hi,2=B_lo,3=B_hi); dp_wr  out  1: datapath register write, one cycle per write.
REQ-008 dp_op  out  2; dp_signed  out  1; dp_start  out  1 (one-cycle pulse); dp_abort  out  1 (one-cycle pulse).
REQ-009 dp_done  in  1; dp_flags  in  2 ({overflow, negative}), valid when dp_done=1.
REQ-010 dp_rd_sel  out  2; dp_rd_data  in  8: combinational readback of the selected byte, same cycle.
REQ-011 rsp_valid  out  1; rsp_ready  in  1; rsp_data  out  16; rsp_flags  out  2; rsp_err  out  1.

Function
REQ-012 States: IDLE, LD_A, LD_B, EXEC, WAIT, RD_LO, RD_HI, RESP, ABORT.
REQ-013 cmd_ready SHALL be 1 only in IDLE; handshake moves IDLE->LD_A and latches op, signed, a, b.
REQ-014 LD_A: dp_wr=1, dp_reg=0, dp_data=a; LD_B: dp_wr=1, dp_reg=2, dp_data=b; one cycle each.
REQ-015 LD_B -> RD_LO when op=LDR, else -> EXEC.
REQ-016 EXEC: dp_start=1, dp_op/dp_signed = latched values, one cycle; -> WAIT.
REQ-017 WAIT: on dp_done=1 capture dp_flags, -> RD_LO; dp_done outside WAIT SHALL be ignored.
REQ-018 RD_LO: dp_rd_sel=2, capture dp_rd_data into rsp_data[7:0]; RD_HI: dp_rd_sel=3, into rsp_data[15:8].
REQ-019 RESP: rsp_valid=1, data/flags/err stable until rsp_valid&rsp_ready; then -> IDLE (no accept in same cycle).
REQ-020 Latency: handshake cycle 0, dp_start cycle 3, dp_done at cycle d>=4 gives rsp_valid at d+3; LDR gives rsp_valid at cycle 5.
REQ-021 LDR response: rsp_flags=00.
REQ-022 dp_op, dp_signed held at latched values from EXEC through RD_HI; dp_wr, dp_start, dp_abort 0 outside their states.

Reset
REQ-023 rst_n low SHALL force IDLE asynchronously; all outputs 0 including cmd_ready and rsp_valid; latches cleared.
REQ-024 cmd_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-025 Reset mid-operation SHALL abandon the command with no response and no dp_abort pulse.

Configuration
REQ-026 Macro ARITH_SEQ_TIMEOUT_EN defined: WAIT counter increments each WAIT cycle; on reaching TIMEOUT_CYCLES without dp_done -> ABORT (dp_abort=1 one cycle) -> RESP with rsp_err=1, rsp_data=0, rsp_flags=00.
REQ-027 dp_done and timeout in same cycle: dp_done wins.
REQ-028 Macro undefined: WAIT unbounded, no counter logic, rsp_err and dp_abort tied 0, ABORT state absent.

Structure
REQ-029 Package arith_seq_pkg SHALL hold the state enum, op-code constants (LDR/ADD/SUB/MUL) and dp_reg select constants.
REQ-030 Sub-module arith_seq_timer (clear, enable, terminal-count output) SHALL implement the watchdog, instantiated only with ARITH_SEQ_TIMEOUT_EN.

Verification
REQ-031 Reset then idle -> cmd_ready=1 first cycle after rst_n rises; all other outputs 0.
REQ-032 LDR a=0x34 b=0x12, rsp_ready=1, model returns 0x34/0x12 -> dp_wr pulses cycles 1,2, no dp_start, rsp_valid cycle 5, rsp_data=0x1234.
REQ-033 MUL signed a=0xFD b=0x05, model dp_done at cycle 8, bytes 0xF1/0xFF, flags 01 -> rsp_data=0xFFF1, rsp_flags=01, rsp_valid cycle 11.
REQ-034 ADD with rsp_ready low 4 cycles -> rsp_valid held, data stable; cmd_valid held high is not accepted until cycle after RESP handshake.
REQ-035 (TIMEOUT_EN, TIMEOUT_CYCLES=32) SUB, dp_done never -> dp_abort pulse after 32 WAIT cycles, rsp_err=1, rsp_data=0; repeat with dp_done on 32nd cycle -> normal response, rsp_err=0.
REQ-036 rst_n pulsed low during WAIT -> immediate IDLE, no rsp_valid, no dp_abort; next command completes normally.

Source files
------------

// File: rtl/arith_seq_pkg.sv
// Shared types and constants for the arithmetic command sequencer.
// The ABORT state exists only when ARITH_SEQ_TIMEOUT_EN is defined.
package arith_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_A,
        S_LD_B,
        S_EXEC,
        S_WAIT,
        S_RD_LO,
        S_RD_HI,
        S_RESP
`ifdef ARITH_SEQ_TIMEOUT_EN
        , S_ABORT
`endif
    } state_t;

    localparam logic [1:0] OP_LDR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam logic [1:0] REG_A_LO = 2'd0;
    localparam logic [1:0] REG_A_HI = 2'd1;
    localparam logic [1:0] REG_B_LO = 2'd2;
    localparam logic [1:0] REG_B_HI = 2'd3;

    // Operand A goes straight to dp_data at handshake, so only op/sign/B are held.
    typedef struct packed {
        logic [1:0] op;
        logic       sgn;
        logic [7:0] b;
    } cmd_t;

endpackage

// File: rtl/arith_seq_timer.sv
// WAIT-state watchdog: counts enabled cycles, tc marks the LIMIT-th enabled cycle.
module arith_seq_timer #(
    parameter int unsigned LIMIT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [7:0] cnt;

    assign tc = enable && (cnt == 8'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !tc)
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/arith_sequencer.sv
// Command sequencer driving an external 8-bit arithmetic datapath.
// Define ARITH_SEQ_TIMEOUT_EN to bound the WAIT state with a watchdog abort.
module arith_sequencer
    import arith_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic        cmd_signed,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [7:0]  dp_data,
    output logic [1:0]  dp_reg,
    output logic        dp_wr,
    output logic [1:0]  dp_op,
    output logic        dp_signed,
    output logic        dp_start,
    output logic        dp_abort,
    input  logic        dp_done,
    input  logic [1:0]  dp_flags,
    output logic [1:0]  dp_rd_sel,
    input  logic [7:0]  dp_rd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_flags,
    output logic        rsp_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("arith_sequencer: TIMEOUT_CYCLES must be 2..255");
    end

    state_t state;
    cmd_t   cmd_q;

`ifdef ARITH_SEQ_TIMEOUT_EN
    logic timeout;

    arith_seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != S_WAIT),
        .enable (state == S_WAIT),
        .tc     (timeout)
    );
`else
    assign dp_abort = 1'b0;
    assign rsp_err  = 1'b0;
`endif

    // Every output is registered: it is set on the edge entering the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            cmd_ready <= 1'b0;
            dp_data   <= '0;
            dp_reg    <= '0;
            dp_wr     <= 1'b0;
            dp_op     <= '0;
            dp_signed <= 1'b0;
            dp_start  <= 1'b0;
            dp_rd_sel <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
`ifdef ARITH_SEQ_TIMEOUT_EN
            dp_abort  <= 1'b0;
            rsp_err   <= 1'b0;
`endif
        end else begin
            dp_wr    <= 1'b0;
            dp_start <= 1'b0;
`ifdef ARITH_SEQ_TIMEOUT_EN
            dp_abort <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_q     <= '{op: cmd_op, sgn: cmd_signed, b: cmd_b};
                        cmd_ready <= 1'b0;
                        dp_wr     <= 1'b1;
                        dp_reg    <= REG_A_LO;
                        dp_data   <= cmd_a;
                        rsp_data  <= '0;
                        rsp_flags <= '0;
`ifdef ARITH_SEQ_TIMEOUT_EN
                        rsp_err   <= 1'b0;
`endif
                        state     <= S_LD_A;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_LD_A: begin
                    dp_wr   <= 1'b1;
                    dp_reg  <= REG_B_LO;
                    dp_data <= cmd_q.b;
                    state   <= S_LD_B;
                end
                S_LD_B: begin
                    dp_reg  <= '0;
                    dp_data <= '0;
                    if (cmd_q.op == OP_LDR) begin
                        dp_rd_sel <= REG_B_LO;
                        state     <= S_RD_LO;
                    end else begin
                        dp_start  <= 1'b1;
                        dp_op     <= cmd_q.op;
                        dp_signed <= cmd_q.sgn;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: state <= S_WAIT;
                S_WAIT: begin
                    // dp_done has priority over a watchdog expiry in the same cycle
                    if (dp_done) begin
                        rsp_flags <= dp_flags;
                        dp_rd_sel <= REG_B_LO;
                        state     <= S_RD_LO;
                    end
`ifdef ARITH_SEQ_TIMEOUT_EN
                    else if (timeout) begin
                        dp_abort  <= 1'b1;
                        dp_op     <= '0;
                        dp_signed <= 1'b0;
                        state     <= S_ABORT;
                    end
`endif
                end
                S_RD_LO: begin
                    rsp_data[7:0] <= dp_rd_data;
                    dp_rd_sel     <= REG_B_HI;
                    state         <= S_RD_HI;
                end
                S_RD_HI: begin
                    rsp_data[15:8] <= dp_rd_data;
                    dp_rd_sel      <= '0;
                    dp_op          <= '0;
                    dp_signed      <= 1'b0;
                    rsp_valid      <= 1'b1;
                    state          <= S_RESP;
                end
`ifdef ARITH_SEQ_TIMEOUT_EN
                S_ABORT: begin
                    rsp_data  <= '0;
                    rsp_flags <= '0;
                    rsp_err   <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arith_sequencer.sv
// Directed bench for arith_sequencer with a transaction-level model and per-cycle compare.
// Timeout vectors run only when ARITH_SEQ_TIMEOUT_EN is defined.
module tb_arith_sequencer;
    import arith_seq_pkg::*;

    localparam int TO = 32;
`ifdef ARITH_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_signed;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a, cmd_b;
    logic [7:0]  dp_data;
    logic [1:0]  dp_reg, dp_op, dp_rd_sel, dp_flags;
    logic        dp_wr, dp_signed, dp_start, dp_abort, dp_done;
    logic [7:0]  dp_rd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_flags;

    arith_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_signed(cmd_signed),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .dp_data(dp_data), .dp_reg(dp_reg), .dp_wr(dp_wr), .dp_op(dp_op), .dp_signed(dp_signed),
        .dp_start(dp_start), .dp_abort(dp_abort), .dp_done(dp_done), .dp_flags(dp_flags),
        .dp_rd_sel(dp_rd_sel), .dp_rd_data(dp_rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Arithmetic the datapath performs, on sign- or zero-extended 16-bit operands.
    function automatic logic [15:0] res16(input logic [1:0] op, input logic s,
                                          input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'h00, a};
        eb = s ? {{8{b[7]}}, b} : {8'h00, b};
        case (op)
            OP_LDR:  return {b, a};
            OP_ADD:  return ea + eb;
            OP_SUB:  return ea - eb;
            default: return ea * eb;
        endcase
    endfunction

    function automatic logic [1:0] flags2(input logic [15:0] r);
        return {(r[15:8] != {8{r[7]}}), r[15]};
    endfunction

    // Datapath model: operand registers, result register, combinational readback.
    logic [7:0]  m_a, m_b;
    logic [15:0] m_r;
    always @(posedge clk) begin
        if (dp_wr && dp_reg == REG_A_LO) begin m_a <= dp_data; m_r[7:0]  <= dp_data; end
        if (dp_wr && dp_reg == REG_B_LO) begin m_b <= dp_data; m_r[15:8] <= dp_data; end
        if (dp_start) m_r <= res16(dp_op, dp_signed, m_a, m_b);
    end
    assign dp_rd_data = (dp_rd_sel == REG_B_LO) ? m_r[7:0] :
                        (dp_rd_sel == REG_B_HI) ? m_r[15:8] : 8'h00;

    // Transaction model: 0 = just out of reset, 1 = idle, 2 = busy with a command.
    int          mstate = 0;
    int          cyc = 0, t0 = 0, mk = 0;
    int          cur_dd = 0;
    int          rsp_k, abort_k, hold_end;
    int          hs_cnt = 0, rsp_cnt = 0, first_rsp_k = -1;
    logic [1:0]  c_op;
    logic        c_sgn;
    logic [7:0]  c_a, c_b;
    logic [15:0] exp_data, last_rsp_data;
    logic [1:0]  exp_flags;
    logic        exp_err;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("reset_outputs", {cmd_ready, dp_wr, dp_start, dp_abort, rsp_valid, rsp_err,
                                  dp_op, dp_signed, dp_rd_sel, dp_reg, dp_data, rsp_flags}, 32'd0);
            chk("reset_rsp_data", rsp_data, 32'd0);
            mstate = 0;
        end else begin
            chk("cmd_ready", cmd_ready, mstate == 1);
            if (mstate == 2) begin
                mk = cyc - t0;
                chk("dp_wr", dp_wr, (mk == 1 || mk == 2));
                if (mk == 1 || mk == 2) begin
                    chk("dp_reg", dp_reg, (mk == 1) ? REG_A_LO : REG_B_LO);
                    chk("dp_data", dp_data, (mk == 1) ? c_a : c_b);
                end
                chk("dp_start", dp_start, (c_op != OP_LDR && mk == 3));
                if (c_op != OP_LDR && mk >= 3 && mk <= hold_end)
                    chk("dp_op_signed", {dp_op, dp_signed}, {c_op, c_sgn});
                chk("dp_abort", dp_abort, mk == abort_k);
                chk("rsp_valid", rsp_valid, mk >= rsp_k);
                if (rsp_valid && first_rsp_k < 0) first_rsp_k = mk;
                if (mk >= rsp_k) begin
                    chk("rsp_data", rsp_data, exp_data);
                    chk("rsp_flags", rsp_flags, exp_flags);
                    chk("rsp_err", rsp_err, exp_err);
                    if (rsp_ready) begin
                        last_rsp_data = rsp_data;
                        rsp_cnt++;
                        mstate = 1;
                    end
                end
            end else begin
                chk("idle_strobes", {dp_wr, dp_start, dp_abort, rsp_valid}, 32'd0);
                if (mstate == 0) begin
                    mstate = 1;
                end else if (cmd_valid) begin
                    t0 = cyc; c_op = cmd_op; c_sgn = cmd_signed; c_a = cmd_a; c_b = cmd_b;
                    first_rsp_k = -1; abort_k = -1; exp_err = 1'b0;
                    if (cmd_op == OP_LDR) begin
                        rsp_k = 5; exp_data = {cmd_b, cmd_a}; exp_flags = 2'b00;
                    end else if (cur_dd >= 4 && (!TO_EN || cur_dd <= 3 + TO)) begin
                        rsp_k = cur_dd + 3;
                        exp_data = res16(cmd_op, cmd_signed, cmd_a, cmd_b);
                        exp_flags = flags2(exp_data);
                    end else begin
                        abort_k = 4 + TO; rsp_k = 5 + TO;
                        exp_data = 16'h0; exp_flags = 2'b00; exp_err = 1'b1;
                    end
                    hold_end = (abort_k > 0) ? abort_k - 1 : rsp_k - 1;
                    hs_cnt++;
                    mstate = 2;
                end
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic s, input logic [7:0] a,
                        input logic [7:0] b, input int dd, output bit ok);
        int h;
        cur_dd = dd;
        cmd_valid = 1'b1; cmd_op = op; cmd_signed = s; cmd_a = a; cmd_b = b;
        h = hs_cnt;
        for (int n = 0; n < 20 && hs_cnt == h; n++) @(posedge clk);
        ok = (hs_cnt != h);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: got no cmd handshake expected one within 20 cycles");
            cmd_valid = 1'b0;
        end
        #1;
    endtask

    // dd: cycle of the dp_done pulse relative to the handshake (0 = never).
    task automatic run_cmd(input logic [1:0] op, input logic s, input logic [7:0] a,
                           input logic [7:0] b, input int dd, input int hold,
                           input bit keep, input bit spur);
        int r, held;
        bit ok, got;
        logic [15:0] res;
        res = res16(op, s, a, b);
        r = rsp_cnt;
        held = 0;
        got = 1'b0;
        send(op, s, a, b, dd, ok);
        if (!ok) return;
        if (!keep) cmd_valid = 1'b0;
        for (int k = 1; k < 100 && !got; k++) begin
            dp_done  = (k == dd) || (spur && k == 1);
            dp_flags = (k == dd) ? flags2(res) : 2'b11;
            if (rsp_valid) begin
                if (held < hold) begin rsp_ready = 1'b0; held++; end
                else rsp_ready = 1'b1;
            end else begin
                rsp_ready = (hold == 0);
            end
            @(posedge clk);
            got = (rsp_cnt != r);
            #1;
        end
        dp_done = 1'b0; dp_flags = 2'b00; rsp_ready = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL response_timeout: got no response expected one within 100 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int r;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_signed = 1'b0;
        cmd_a = 8'h00; cmd_b = 8'h00; dp_done = 1'b0; dp_flags = 2'b00; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        chk("pin_mul_model", res16(OP_MUL, 1'b1, 8'hFD, 8'h05), 32'hFFF1);
        chk("pin_mul_flags", flags2(res16(OP_MUL, 1'b1, 8'hFD, 8'h05)), 32'h1);

        run_cmd(OP_LDR, 1'b0, 8'h34, 8'h12, 0, 0, 1'b0, 1'b0);
        chk("ldr_latency", first_rsp_k, 5);
        chk("ldr_data", last_rsp_data, 32'h1234);

        run_cmd(OP_MUL, 1'b1, 8'hFD, 8'h05, 8, 0, 1'b0, 1'b1);
        chk("mul_latency", first_rsp_k, 11);
        chk("mul_data", last_rsp_data, 32'hFFF1);

        // Response back-pressure with the next command already waiting.
        run_cmd(OP_ADD, 1'b0, 8'h80, 8'h90, 5, 4, 1'b1, 1'b0);
        chk("add_bp_data", last_rsp_data, 32'h0110);
        run_cmd(OP_ADD, 1'b0, 8'h80, 8'h90, 4, 0, 1'b0, 1'b0);
        chk("add_min_latency", first_rsp_k, 7);

        run_cmd(OP_SUB, 1'b1, 8'h05, 8'h09, 6, 0, 1'b0, 1'b0);
        chk("sub_data", last_rsp_data, 32'hFFFC);
        run_cmd(OP_MUL, 1'b0, 8'hFF, 8'hFF, 10, 2, 1'b0, 1'b0);
        chk("umul_data", last_rsp_data, 32'hFE01);

        if (TO_EN) begin
            run_cmd(OP_SUB, 1'b0, 8'h10, 8'h20, 0, 0, 1'b0, 1'b0);
            chk("timeout_latency", first_rsp_k, 37);
            chk("timeout_data", last_rsp_data, 32'h0);
            run_cmd(OP_SUB, 1'b0, 8'h10, 8'h20, 35, 0, 1'b0, 1'b0);
            chk("done_on_last_wait", first_rsp_k, 38);
            chk("done_on_last_data", last_rsp_data, 32'hFFF0);
        end

        // Reset while the datapath is busy abandons the command.
        r = rsp_cnt;
        send(OP_SUB, 1'b1, 8'h33, 8'h11, 0, ok);
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_rsp_after_reset", rsp_cnt, r);
        run_cmd(OP_ADD, 1'b0, 8'h12, 8'h34, 4, 0, 1'b0, 1'b0);
        chk("post_reset_data", last_rsp_data, 32'h0046);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
